// File: rtl/writeback_ctrl.sv
// Writer side of the integer register file: captures ALU results and load data,
// formats loads (lane select + sign/zero extend), and drives the regfile write port
// for exactly one cycle while the core FSM sits in WRITE_BACK.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   state                         core FSM state (WRITE_BACK / TRAP are decoded here)
//   alu_valid/alu_rd/alu_result   ALU result capture (EXECUTE)
//   load_issue/load_rd/load_funct3/load_addr_lo   load issue descriptor
//   mem_rvalid/mem_rdata/mem_err  load data return (MEM_WAIT)
//   rd/result/reg_write           regfile write port
//   wb_done, wb_fault             slot consumed / load dropped pulse
//   pending_valid/pending_rd      outstanding destination for hazard checks
//
// Optional feature: define WB_RETIRE_CNT_EN to add retire_cnt[31:0], a wrapping count
// of cycles with reg_write=1.
module writeback_ctrl #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             alu_valid,
  input  logic [RADDR-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             load_issue,
  input  logic [RADDR-1:0] load_rd,
  input  logic [2:0]       load_funct3,
  input  logic [1:0]       load_addr_lo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_err,
  output logic [RADDR-1:0] rd,
  output logic [XLEN-1:0]  result,
  output logic             reg_write,
  output logic             wb_done,
  output logic             wb_fault,
  output logic             pending_valid,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]      retire_cnt,
`endif
  output logic [RADDR-1:0] pending_rd
);

  localparam logic [2:0] CORE_WRITE_BACK = 3'b011;
  localparam logic [2:0] CORE_TRAP       = 3'b101;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_HOLD      = 2'd2
  } wb_state_t;

  wb_state_t        fsm;
  logic [RADDR-1:0] hold_rd;
  logic [XLEN-1:0]  hold_data;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;

  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [XLEN-1:0]  load_fmt;
  logic             funct3_legal;
  logic             in_wb;
  logic             trap;

  assign in_wb = (state == CORE_WRITE_BACK);
  assign trap  = (state == CORE_TRAP);

  always_comb begin
    funct3_legal = 1'b0;
    case (load_funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_legal = 1'b1;
      default:                             funct3_legal = 1'b0;
    endcase
  end

  // Lane select uses the latched address; addr_lo[0] is ignored for halves since
  // misaligned halves never reach this block.
  always_comb begin
    byte_lane = mem_rdata[{ld_addr_lo, 3'b000} +: 8];
    half_lane = mem_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    load_fmt  = mem_rdata;
    case (ld_funct3)
      F3_LB:   load_fmt = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   load_fmt = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  load_fmt = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  load_fmt = {{(XLEN-16){1'b0}}, half_lane};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      hold_rd    <= '0;
      hold_data  <= '0;
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
      wb_fault   <= 1'b0;
    end else begin
      wb_fault <= 1'b0;
      if (trap) begin
        // Abort drops whatever is in flight; a late mem_rvalid lands in S_IDLE and is ignored.
        fsm <= S_IDLE;
      end else begin
        case (fsm)
          S_IDLE: begin
            if (load_issue) begin
              if (funct3_legal) begin
                hold_rd    <= load_rd;
                ld_funct3  <= load_funct3;
                ld_addr_lo <= load_addr_lo;
                fsm        <= S_LOAD_WAIT;
              end else begin
                wb_fault <= 1'b1;
              end
            end else if (alu_valid) begin
              hold_rd   <= alu_rd;
              hold_data <= alu_result;
              fsm       <= S_HOLD;
            end
          end
          S_LOAD_WAIT: begin
            if (mem_rvalid) begin
              if (mem_err) begin
                wb_fault <= 1'b1;
                fsm      <= S_IDLE;
              end else begin
                hold_data <= load_fmt;
                fsm       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (in_wb) fsm <= S_IDLE;
          end
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

  // Write port is combinational off the holding regs so the write lands in the
  // same WRITE_BACK cycle; leaving S_HOLD on the next edge makes it a single pulse.
  always_comb begin
    rd            = '0;
    result        = '0;
    reg_write     = 1'b0;
    wb_done       = 1'b0;
    pending_valid = (fsm != S_IDLE);
    pending_rd    = (fsm != S_IDLE) ? hold_rd : '0;
    if (fsm == S_HOLD) begin
      rd     = hold_rd;
      result = hold_data;
      if (in_wb) begin
        wb_done   = 1'b1;
        reg_write = (hold_rd != '0);
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)            retire_cnt <= '0;
    else if (reg_write) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl: hand-computed vectors, one task per scenario.
module tb_writeback_ctrl;

  localparam logic [2:0] FETCH = 3'b000, EXECUTE = 3'b010, WB = 3'b011,
                         MEMW = 3'b100, TRAP = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_issue;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [4:0]  rd;
  logic [31:0] result;
  logic        reg_write;
  logic        wb_done;
  logic        wb_fault;
  logic        pending_valid;
  logic [4:0]  pending_rd;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  writeback_ctrl dut (
    .clk(clk), .rst(rst), .state(state),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .load_issue(load_issue), .load_rd(load_rd), .load_funct3(load_funct3),
    .load_addr_lo(load_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .rd(rd), .result(result), .reg_write(reg_write),
    .wb_done(wb_done), .wb_fault(wb_fault), .pending_valid(pending_valid),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .pending_rd(pending_rd)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    state = FETCH; alu_valid = 0; alu_rd = 0; alu_result = 0;
    load_issue = 0; load_rd = 0; load_funct3 = 0; load_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
  endtask

  task automatic issue_alu(input logic [4:0] r, input logic [31:0] v);
    state = EXECUTE; alu_valid = 1; alu_rd = r; alu_result = v;
    tick();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
  endtask

  // Issue a load and return good data; leaves the block in S_HOLD.
  task automatic run_load(input logic [2:0] f3, input logic [1:0] a,
                          input logic [4:0] r, input logic [31:0] d);
    state = EXECUTE; load_issue = 1; load_funct3 = f3; load_addr_lo = a; load_rd = r;
    tick();
    load_issue = 0; load_funct3 = 0; load_addr_lo = 0; load_rd = 0;
    state = MEMW; mem_rvalid = 1; mem_rdata = d;
    tick();
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    nvec++;
    if ({rd, result, reg_write, wb_done, wb_fault, pending_valid, pending_rd} !== 47'd0) begin
      nerr++;
      $display("FAIL reset_outputs got rd=%0d res=%h rw=%b done=%b flt=%b pv=%b prd=%0d want all 0",
               rd, result, reg_write, wb_done, wb_fault, pending_valid, pending_rd);
    end
  endtask

  task automatic test_alu_write();
    issue_alu(5'd5, 32'hDEADBEEF);
    nvec++;
    if (pending_valid !== 1'b1 || pending_rd !== 5'd5 || reg_write !== 1'b0 || wb_done !== 1'b0) begin
      nerr++;
      $display("FAIL alu_hold got pv=%b prd=%0d rw=%b done=%b want 1 5 0 0",
               pending_valid, pending_rd, reg_write, wb_done);
    end
    state = WB; #1;
    nvec++;
    if (reg_write !== 1'b1 || wb_done !== 1'b1 || rd !== 5'd5 || result !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL alu_wb got rw=%b done=%b rd=%0d res=%h want 1 1 5 deadbeef",
               reg_write, wb_done, rd, result);
    end
    exp_retire++;
    tick();
    nvec++;
    if (reg_write !== 1'b0 || wb_done !== 1'b0 || pending_valid !== 1'b0) begin
      nerr++;
      $display("FAIL alu_one_cycle got rw=%b done=%b pv=%b want 0 0 0", reg_write, wb_done, pending_valid);
    end
    state = FETCH;
  endtask

  task automatic test_load_format();
    // LB lane 2 of 0x12F45678 -> 0xF4 sign-extended
    run_load(3'b000, 2'd2, 5'd7, 32'h12F45678);
    state = WB; #1;
    nvec++;
    if (reg_write !== 1'b1 || rd !== 5'd7 || result !== 32'hFFFFFFF4) begin
      nerr++;
      $display("FAIL lb got rw=%b rd=%0d res=%h want 1 7 fffffff4", reg_write, rd, result);
    end
    exp_retire++;
    tick(); state = FETCH;

    run_load(3'b101, 2'd2, 5'd3, 32'h80010000);
    state = WB; #1;
    nvec++;
    if (result !== 32'h00008001 || reg_write !== 1'b1) begin
      nerr++;
      $display("FAIL lhu got res=%h rw=%b want 00008001 1", result, reg_write);
    end
    exp_retire++;
    tick(); state = FETCH;

    run_load(3'b001, 2'd2, 5'd3, 32'h80010000);
    state = WB; #1;
    nvec++;
    if (result !== 32'hFFFF8001) begin
      nerr++;
      $display("FAIL lh got res=%h want ffff8001", result);
    end
    exp_retire++;
    tick(); state = FETCH;

    // LBU lane 1 of 0x0000A500 -> 0xA5 zero-extended
    run_load(3'b100, 2'd1, 5'd12, 32'h0000A500);
    state = WB; #1;
    nvec++;
    if (result !== 32'h000000A5) begin
      nerr++;
      $display("FAIL lbu got res=%h want 000000a5", result);
    end
    exp_retire++;
    tick(); state = FETCH;

    // LH lane 0 of 0x7FFF8000 -> 0x8000 sign-extended; addr_lo[0] ignored
    run_load(3'b001, 2'd1, 5'd13, 32'h7FFF8000);
    state = WB; #1;
    nvec++;
    if (result !== 32'hFFFF8000) begin
      nerr++;
      $display("FAIL lh_lane0 got res=%h want ffff8000", result);
    end
    exp_retire++;
    tick(); state = FETCH;

    run_load(3'b010, 2'd0, 5'd31, 32'hCAFE0123);
    state = WB; #1;
    nvec++;
    if (result !== 32'hCAFE0123 || rd !== 5'd31) begin
      nerr++;
      $display("FAIL lw got rd=%0d res=%h want 31 cafe0123", rd, result);
    end
    exp_retire++;
    tick(); state = FETCH;
  endtask

  task automatic test_rd_zero();
    issue_alu(5'd0, 32'h00001234);
    state = WB; #1;
    nvec++;
    if (wb_done !== 1'b1 || reg_write !== 1'b0) begin
      nerr++;
      $display("FAIL rd_zero got done=%b rw=%b want 1 0", wb_done, reg_write);
    end
    tick(); state = FETCH;
  endtask

  task automatic test_trap_abort();
    state = EXECUTE; load_issue = 1; load_funct3 = 3'b010; load_rd = 5'd9;
    tick();
    load_issue = 0;
    nvec++;
    if (pending_valid !== 1'b1 || pending_rd !== 5'd9) begin
      nerr++;
      $display("FAIL trap_pending got pv=%b prd=%0d want 1 9", pending_valid, pending_rd);
    end
    state = TRAP;
    tick();
    state = MEMW; mem_rvalid = 1; mem_rdata = 32'h55555555;
    tick();
    mem_rvalid = 0;
    state = WB; #1;
    nvec++;
    if (pending_valid !== 1'b0 || reg_write !== 1'b0 || wb_done !== 1'b0 || pending_rd !== 5'd0) begin
      nerr++;
      $display("FAIL trap_abort got pv=%b rw=%b done=%b prd=%0d want 0 0 0 0",
               pending_valid, reg_write, wb_done, pending_rd);
    end
    tick(); state = FETCH;
  endtask

  task automatic test_fault();
    state = EXECUTE; load_issue = 1; load_funct3 = 3'b010; load_rd = 5'd4;
    tick();
    load_issue = 0;
    state = MEMW; mem_rvalid = 1; mem_err = 1;
    tick();
    mem_rvalid = 0; mem_err = 0;
    nvec++;
    if (wb_fault !== 1'b1 || pending_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mem_err got flt=%b pv=%b want 1 0", wb_fault, pending_valid);
    end
    state = WB;
    tick();
    nvec++;
    if (wb_fault !== 1'b0 || reg_write !== 1'b0 || wb_done !== 1'b0) begin
      nerr++;
      $display("FAIL mem_err_pulse got flt=%b rw=%b done=%b want 0 0 0", wb_fault, reg_write, wb_done);
    end
    // Illegal funct3 3'b011: fault next cycle, stays idle
    state = EXECUTE; load_issue = 1; load_funct3 = 3'b011; load_rd = 5'd8;
    tick();
    load_issue = 0;
    nvec++;
    if (wb_fault !== 1'b1 || pending_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bad_funct3 got flt=%b pv=%b want 1 0", wb_fault, pending_valid);
    end
    tick();
    nvec++;
    if (wb_fault !== 1'b0) begin
      nerr++;
      $display("FAIL bad_funct3_pulse got flt=%b want 0", wb_fault);
    end
    state = FETCH;
  endtask

  task automatic test_priority();
    // load and ALU together: load wins
    state = EXECUTE; load_issue = 1; load_funct3 = 3'b010; load_rd = 5'd10;
    alu_valid = 1; alu_rd = 5'd11; alu_result = 32'h11111111;
    tick();
    load_issue = 0; alu_valid = 0;
    nvec++;
    if (pending_rd !== 5'd10) begin
      nerr++;
      $display("FAIL load_wins got prd=%0d want 10", pending_rd);
    end
    // new ALU op while waiting is ignored
    alu_valid = 1; alu_rd = 5'd20; alu_result = 32'h22222222;
    state = MEMW; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    tick();
    alu_valid = 0; mem_rvalid = 0;
    state = WB; #1;
    nvec++;
    if (rd !== 5'd10 || result !== 32'h0BADF00D || reg_write !== 1'b1) begin
      nerr++;
      $display("FAIL load_only got rd=%0d res=%h rw=%b want 10 0badf00d 1", rd, result, reg_write);
    end
    exp_retire++;
    tick(); state = FETCH;
  endtask

  task automatic test_back_to_back();
    issue_alu(5'd1, 32'hA0A0A0A0);
    state = WB; #1;
    nvec++;
    if (rd !== 5'd1 || result !== 32'hA0A0A0A0 || reg_write !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_first got rd=%0d res=%h rw=%b want 1 a0a0a0a0 1", rd, result, reg_write);
    end
    exp_retire++;
    tick();
    issue_alu(5'd2, 32'h0F0F0F0F);
    state = WB; #1;
    nvec++;
    if (rd !== 5'd2 || result !== 32'h0F0F0F0F || reg_write !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_second got rd=%0d res=%h rw=%b want 2 0f0f0f0f 1", rd, result, reg_write);
    end
    exp_retire++;
    tick(); state = FETCH;
  endtask

  task automatic test_hold_and_reset();
    issue_alu(5'd6, 32'h66666666);
    state = FETCH;
    tick(); tick();
    nvec++;
    if (pending_valid !== 1'b1 || rd !== 5'd6 || reg_write !== 1'b0 || wb_done !== 1'b0) begin
      nerr++;
      $display("FAIL hold_wait got pv=%b rd=%0d rw=%b done=%b want 1 6 0 0",
               pending_valid, rd, reg_write, wb_done);
    end
`ifdef WB_RETIRE_CNT_EN
    nvec++;
    if (retire_cnt !== 32'(exp_retire)) begin
      nerr++;
      $display("FAIL retire_cnt got %0d want %0d", retire_cnt, exp_retire);
    end
`endif
    rst = 1;
    tick();
    rst = 0;
    state = WB; #1;
    nvec++;
    if ({rd, result, reg_write, wb_done, wb_fault, pending_valid, pending_rd} !== 47'd0) begin
      nerr++;
      $display("FAIL reset_mid_hold got rd=%0d res=%h rw=%b done=%b pv=%b want all 0",
               rd, result, reg_write, wb_done, pending_valid);
    end
`ifdef WB_RETIRE_CNT_EN
    nvec++;
    if (retire_cnt !== 32'd0) begin
      nerr++;
      $display("FAIL retire_cnt_reset got %0d want 0", retire_cnt);
    end
`endif
    tick(); state = FETCH;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_format();
    test_rd_zero();
    test_trap_abort();
    test_fault();
    test_priority();
    test_back_to_back();
    test_hold_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
